fifo_wr_arbiter: RTL and testbench

Round-robin arbiter that shares the single write port of the asynchronous FIFO memory among `NUM_REQ` write-domain producers. It sits entirely in the write clock domain, directly in front of the FIFO memory's write port. It drives `wr_inc`/`wr_data` and obeys `wr_full` from the write-pointer/full logic. Each cycle it accepts at most one beat, from one requester, through a valid/ready handshake.

---
 rtl/fifo_wr_arbiter.sv | 123 ++++++++++++
 tb/tb_fifo_wr_arbiter.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin arbiter sharing the FIFO memory write port among NUM_REQ producers.
// Define FIFO_WR_ARB_BURST_EN to compile in burst lock (up to BURST_LEN consecutive beats per grant).
module fifo_wr_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8,
    parameter int BURST_LEN  = 4,
    parameter int ID_WIDTH   = $clog2(NUM_REQ)
) (
    input  logic                          wr_clk,
    input  logic                          wr_rst,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic                          wr_full,
    output logic                          wr_inc,
    output logic [DATA_WIDTH-1:0]         wr_data,
    output logic [ID_WIDTH-1:0]           grant_id,
    output logic                          locked
);

    logic [ID_WIDTH-1:0] r_ptr;
    logic [ID_WIDTH-1:0] r_grant_id;
    logic                w_rr_found;
    logic [ID_WIDTH-1:0] w_rr_id;
    logic                w_win_found;
    logic [ID_WIDTH-1:0] w_win_id;
    logic                w_beat;

    function automatic logic [ID_WIDTH-1:0] f_next(input logic [ID_WIDTH-1:0] k);
        return (int'(k) == NUM_REQ - 1) ? '0 : k + ID_WIDTH'(1);
    endfunction

    // First valid requester at or after r_ptr, wrapping modulo NUM_REQ.
    always_comb begin
        w_rr_found = 1'b0;
        w_rr_id    = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!w_rr_found && req_valid[(int'(r_ptr) + i) % NUM_REQ]) begin
                w_rr_found = 1'b1;
                w_rr_id    = ID_WIDTH'((int'(r_ptr) + i) % NUM_REQ);
            end
        end
    end

`ifdef FIFO_WR_ARB_BURST_EN
    localparam int CNT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;

    logic                r_locked;
    logic [ID_WIDTH-1:0] r_lk_id;
    logic [CNT_W-1:0]    r_cnt;
    logic                w_release;

    always_comb begin
        w_release   = r_locked && !req_valid[r_lk_id];
        w_win_found = r_locked ? req_valid[r_lk_id] : w_rr_found;
        w_win_id    = r_locked ? r_lk_id : w_rr_id;
    end

    always_ff @(posedge wr_clk or negedge wr_rst) begin
        if (!wr_rst) begin
            r_ptr      <= '0;
            r_grant_id <= '0;
            r_locked   <= 1'b0;
            r_lk_id    <= '0;
            r_cnt      <= '0;
        end else if (w_release) begin
            r_locked <= 1'b0;
            r_cnt    <= '0;
            r_ptr    <= f_next(r_lk_id);
        end else if (w_beat) begin
            r_grant_id <= w_win_id;
            if (int'(r_cnt) + 1 == BURST_LEN) begin
                r_locked <= 1'b0;
                r_cnt    <= '0;
                r_ptr    <= f_next(w_win_id);
            end else begin
                r_locked <= 1'b1;
                r_lk_id  <= w_win_id;
                r_cnt    <= r_cnt + CNT_W'(1);
            end
        end
    end

    assign locked = r_locked;
`else
    // Without burst lock the grant rotates after every beat, so BURST_LEN has no effect.
    localparam int unused_burst_len = BURST_LEN;

    always_comb begin
        w_win_found = w_rr_found;
        w_win_id    = w_rr_id;
    end

    always_ff @(posedge wr_clk or negedge wr_rst) begin
        if (!wr_rst) begin
            r_ptr      <= '0;
            r_grant_id <= '0;
        end else if (w_beat) begin
            r_grant_id <= w_win_id;
            r_ptr      <= f_next(w_win_id);
        end
    end

    assign locked = 1'b0;
`endif

    // Reset low gates every beat, which also forces req_ready/wr_inc/wr_data to zero.
    assign w_beat   = wr_rst && !wr_full && w_win_found;
    assign wr_inc   = w_beat;
    assign grant_id = r_grant_id;

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_ready
        assign req_ready[gi] = w_beat && (int'(w_win_id) == gi);
    end

    always_comb begin
        wr_data = '0;
        if (w_beat) begin
            wr_data = req_data[int'(w_win_id)*DATA_WIDTH +: DATA_WIDTH];
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Testbench for fifo_wr_arbiter: directed scenarios plus randomized traffic against a reference model.
// Works with or without FIFO_WR_ARB_BURST_EN defined.
module tb_fifo_wr_arbiter;

    localparam int N  = 4;
    localparam int DW = 8;
    localparam int BL = 4;
    localparam int IW = 2;

`ifdef FIFO_WR_ARB_BURST_EN
    localparam bit BURST = 1'b1;
`else
    localparam bit BURST = 1'b0;
`endif

    logic            wr_clk = 1'b0;
    logic            wr_rst = 1'b0;
    logic [N-1:0]    req_valid = '0;
    logic [N*DW-1:0] req_data = '0;
    logic            wr_full = 1'b0;
    logic [N-1:0]    req_ready;
    logic            wr_inc;
    logic [DW-1:0]   wr_data;
    logic [IW-1:0]   grant_id;
    logic            locked;

    int n_vec = 0;
    int n_err = 0;

    // Reference model state
    int m_ptr, m_grant, m_locked, m_lk, m_cnt;
    logic [N-1:0]  e_ready;
    logic          e_inc;
    logic [DW-1:0] e_data;
    int            e_win;

    always #5 wr_clk = ~wr_clk;

    fifo_wr_arbiter #(
        .NUM_REQ(N), .DATA_WIDTH(DW), .BURST_LEN(BL), .ID_WIDTH(IW)
    ) dut (
        .wr_clk(wr_clk), .wr_rst(wr_rst), .req_valid(req_valid), .req_data(req_data),
        .req_ready(req_ready), .wr_full(wr_full), .wr_inc(wr_inc), .wr_data(wr_data),
        .grant_id(grant_id), .locked(locked)
    );

    task automatic model_reset();
        m_ptr = 0; m_grant = 0; m_locked = 0; m_lk = 0; m_cnt = 0;
    endtask

    task automatic model_eval();
        e_win = -1;
        if (wr_rst && !wr_full) begin
            if (m_locked != 0) begin
                if (req_valid[m_lk]) e_win = m_lk;
            end else begin
                for (int i = 0; i < N; i++) begin
                    int k;
                    k = (m_ptr + i) % N;
                    if (e_win < 0 && req_valid[k]) e_win = k;
                end
            end
        end
        e_ready = '0;
        e_inc   = 1'b0;
        e_data  = '0;
        if (e_win >= 0) begin
            e_ready[e_win] = 1'b1;
            e_inc          = 1'b1;
            e_data         = req_data[e_win*DW +: DW];
        end
    endtask

    task automatic model_update();
        if (m_locked != 0 && !req_valid[m_lk]) begin
            m_locked = 0; m_cnt = 0; m_ptr = (m_lk + 1) % N;
        end else if (e_win >= 0) begin
            m_grant = e_win;
            if (BURST) begin
                if (m_cnt + 1 == BL) begin
                    m_locked = 0; m_cnt = 0; m_ptr = (e_win + 1) % N;
                end else begin
                    m_locked = 1; m_lk = e_win; m_cnt = m_cnt + 1;
                end
            end else begin
                m_ptr = (e_win + 1) % N;
            end
        end
    endtask

    // Advance one clock edge, keeping the model in step.
    task automatic tick();
        model_eval();
        @(posedge wr_clk);
        if (wr_rst) model_update();
        #1;
    endtask

    task automatic do_reset();
        @(posedge wr_clk); #1;
        wr_rst = 1'b0;
        model_reset();
        @(posedge wr_clk); #1;
        wr_rst = 1'b1;
    endtask

    task automatic set_seq_data();
        for (int k = 0; k < N; k++) req_data[k*DW +: DW] = 8'(8'h10 + k);
    endtask

    task automatic test_reset();
        wr_rst = 1'b0; req_valid = '1; wr_full = 1'b0; set_seq_data();
        model_reset();
        repeat (2) @(posedge wr_clk);
        @(negedge wr_clk);
        n_vec++; if (req_ready !== 4'b0000) begin n_err++; $display("FAIL reset_ready: got %b want 0000", req_ready); end
        n_vec++; if (wr_inc !== 1'b0) begin n_err++; $display("FAIL reset_inc: got %b want 0", wr_inc); end
        n_vec++; if (wr_data !== 8'h00) begin n_err++; $display("FAIL reset_data: got %h want 00", wr_data); end
        n_vec++; if (grant_id !== 2'd0) begin n_err++; $display("FAIL reset_grant: got %0d want 0", grant_id); end
        n_vec++; if (locked !== 1'b0) begin n_err++; $display("FAIL reset_locked: got %b want 0", locked); end
        @(posedge wr_clk); #1;
        wr_rst = 1'b1;
        @(negedge wr_clk);
        n_vec++; if (req_ready !== 4'b0001 || wr_data !== 8'h10) begin
            n_err++; $display("FAIL reset_first_beat: got ready=%b data=%h want ready=0001 data=10", req_ready, wr_data);
        end
        tick();
        $display("test_reset done: %0d miscompares so far", n_err);
    endtask

    task automatic test_round_robin();
        logic [DW-1:0] exp_lit;
        do_reset();
        req_valid = '1; wr_full = 1'b0; set_seq_data();
        for (int i = 0; i < 8; i++) begin
            @(negedge wr_clk);
            model_eval();
`ifdef FIFO_WR_ARB_BURST_EN
            exp_lit = 8'(8'h10 + ((i / BL) % N));
`else
            exp_lit = 8'(8'h10 + (i % N));
`endif
            n_vec++; if (wr_inc !== 1'b1 || wr_data !== exp_lit) begin
                n_err++; $display("FAIL rr_beat%0d: got inc=%b data=%h want inc=1 data=%h", i, wr_inc, wr_data, exp_lit);
            end
            n_vec++; if (grant_id !== IW'(m_grant) || locked !== (m_locked != 0)) begin
                n_err++; $display("FAIL rr_state%0d: got grant=%0d locked=%b want grant=%0d locked=%0d", i, grant_id, locked, m_grant, m_locked);
            end
            $display("rr beat %0d: data=%h grant_id=%0d", i, wr_data, grant_id);
            tick();
        end
    endtask

    task automatic test_full_backpressure();
        int w_next;
        logic [IW-1:0] g_hold;
        do_reset();
        req_valid = '1; wr_full = 1'b0; set_seq_data();
        tick(); tick();
        model_eval();
        w_next = e_win;
        g_hold = IW'(m_grant);
        wr_full = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge wr_clk);
            n_vec++; if (wr_inc !== 1'b0 || req_ready !== 4'b0000) begin
                n_err++; $display("FAIL full_block%0d: got inc=%b ready=%b want inc=0 ready=0000", i, wr_inc, req_ready);
            end
            n_vec++; if (grant_id !== g_hold) begin
                n_err++; $display("FAIL full_grant_hold%0d: got %0d want %0d", i, grant_id, g_hold);
            end
            tick();
        end
        wr_full = 1'b0;
        @(negedge wr_clk);
        n_vec++; if (req_ready !== 4'(1 << w_next) || wr_data !== 8'(8'h10 + w_next)) begin
            n_err++; $display("FAIL full_resume: got ready=%b data=%h want ready=%b data=%h", req_ready, wr_data, 4'(1 << w_next), 8'(8'h10 + w_next));
        end
        $display("backpressure resume: winner %0d data=%h", w_next, wr_data);
        tick();
    endtask

`ifdef FIFO_WR_ARB_BURST_EN
    task automatic test_burst();
        int id;
        do_reset();
        req_valid = 4'b0110; wr_full = 1'b0; set_seq_data();
        for (int i = 0; i < 8; i++) begin
            id = (i < 4) ? 1 : 2;
            @(negedge wr_clk);
            n_vec++; if (wr_inc !== 1'b1 || req_ready !== 4'(1 << id)) begin
                n_err++; $display("FAIL burst_beat%0d: got inc=%b ready=%b want inc=1 ready=%b", i, wr_inc, req_ready, 4'(1 << id));
            end
            n_vec++; if (locked !== ((i % 4) != 0)) begin
                n_err++; $display("FAIL burst_locked%0d: got %b want %b", i, locked, ((i % 4) != 0));
            end
            $display("burst beat %0d: ready=%b locked=%b", i, req_ready, locked);
            tick();
        end
    endtask

    task automatic test_early_release();
        do_reset();
        req_valid = 4'b1000; wr_full = 1'b0; set_seq_data();
        tick();
        req_valid = 4'b0001;
        @(negedge wr_clk);
        n_vec++; if (wr_inc !== 1'b0 || req_ready !== 4'b0000 || locked !== 1'b1) begin
            n_err++; $display("FAIL release_idle: got inc=%b ready=%b locked=%b want inc=0 ready=0000 locked=1", wr_inc, req_ready, locked);
        end
        tick();
        @(negedge wr_clk);
        n_vec++; if (req_ready !== 4'b0001 || locked !== 1'b0) begin
            n_err++; $display("FAIL release_next: got ready=%b locked=%b want ready=0001 locked=0", req_ready, locked);
        end
        $display("early release: next ready=%b", req_ready);
        tick();
    endtask
`endif

    task automatic test_async_reset();
        do_reset();
        req_valid = '1; wr_full = 1'b0; set_seq_data();
        tick(); tick();
        @(negedge wr_clk); #2;
        wr_rst = 1'b0;
        model_reset();
        #1;
        n_vec++; if (locked !== 1'b0 || grant_id !== 2'd0) begin
            n_err++; $display("FAIL async_clear: got locked=%b grant=%0d want locked=0 grant=0", locked, grant_id);
        end
        n_vec++; if (wr_inc !== 1'b0 || req_ready !== 4'b0000) begin
            n_err++; $display("FAIL async_gate: got inc=%b ready=%b want inc=0 ready=0000", wr_inc, req_ready);
        end
        @(posedge wr_clk); #1;
        n_vec++; if (wr_inc !== 1'b0) begin n_err++; $display("FAIL async_hold_inc: got %b want 0", wr_inc); end
        wr_rst = 1'b1;
        @(negedge wr_clk);
        n_vec++; if (req_ready !== 4'b0001) begin
            n_err++; $display("FAIL async_restart: got ready=%b want 0001", req_ready);
        end
        $display("async reset: restart ready=%b", req_ready);
        tick();
    endtask

    task automatic test_random(int cycles, int p_valid, int p_full);
        do_reset();
        req_valid = '0; wr_full = 1'b0; e_ready = '0;
        for (int c = 0; c < cycles; c++) begin
            // A requester keeps its beat until it has been taken.
            for (int k = 0; k < N; k++) begin
                if (!req_valid[k] || e_ready[k]) begin
                    req_valid[k] = ($urandom_range(99) < p_valid);
                    req_data[k*DW +: DW] = 8'($urandom);
                end
            end
            wr_full = ($urandom_range(99) < p_full);
            @(negedge wr_clk);
            model_eval();
            n_vec++; if (req_ready !== e_ready || wr_inc !== e_inc || wr_data !== e_data) begin
                n_err++; $display("FAIL rand_beat c%0d: got ready=%b inc=%b data=%h want ready=%b inc=%b data=%h",
                                  c, req_ready, wr_inc, wr_data, e_ready, e_inc, e_data);
            end
            n_vec++; if (grant_id !== IW'(m_grant) || locked !== (m_locked != 0)) begin
                n_err++; $display("FAIL rand_state c%0d: got grant=%0d locked=%b want grant=%0d locked=%0d",
                                  c, grant_id, locked, m_grant, m_locked);
            end
            tick();
        end
        wr_full = 1'b0;
        $display("random run (%0d cycles, valid %0d%%, full %0d%%): %0d miscompares so far", cycles, p_valid, p_full, n_err);
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_full_backpressure();
`ifdef FIFO_WR_ARB_BURST_EN
        test_burst();
        test_early_release();
`endif
        test_async_reset();
        test_random(1500, 60, 20);
        test_random(800, 85, 5);
        test_random(500, 30, 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
